// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage data port.
// Aligns byte/half/word accesses onto word RAM with optional wait states.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wr,
  input  logic [3:0]  i_data_rd_en_ctrl,
  input  logic        i_data_rd_en_ma,
  input  logic        i_data_wr_en_ma,
  output logic [31:0] o_data_rd,
  output logic        o_ack,
  output logic        o_stall,
  output logic        o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] addr_q, wdat_q;
  logic [3:0]  ctrl_q;
  logic        rd_q, wr_q;

  logic [31:0] mem [DEPTH];

  logic        req;
  logic [31:0] a_addr, a_wdat;
  logic [3:0]  a_ctrl;
  logic        a_rd, a_wr;
  logic        acc;
  logic        sz_b, sz_h, sz_w;
  logic [1:0]  off;
  logic [AW-1:0] idx;
  logic        err;
  logic [3:0]  lanes;
  logic [31:0] wdat_sh, rword, rsh, rdat;
  logic        unused_addr;

  assign req     = i_data_rd_en_ma | i_data_wr_en_ma;
  assign o_stall = req & ~o_ack;

  // With zero wait states the access happens on the capture edge
  always_comb begin
    a_addr = addr_q;
    a_wdat = wdat_q;
    a_ctrl = ctrl_q;
    a_rd   = rd_q;
    a_wr   = wr_q;
    if (state == IDLE) begin
      a_addr = i_data_addr;
      a_wdat = i_data_wr;
      a_ctrl = i_data_rd_en_ctrl;
      a_rd   = i_data_rd_en_ma;
      a_wr   = i_data_wr_en_ma;
    end
  end

  assign off = a_addr[1:0];
  assign idx = a_addr[AW+1:2];
  assign unused_addr = ^{a_addr[31:AW+2]};

  always_comb begin
    sz_b  = 1'b0;
    sz_h  = 1'b0;
    sz_w  = 1'b0;
    lanes = 4'b1111;
    unique case (1'b1)
      (a_ctrl == 4'b0001): begin
        sz_b  = 1'b1;
        lanes = 4'b0001 << off;
      end
      (a_ctrl == 4'b0011): begin
        sz_h  = 1'b1;
        lanes = 4'b0011 << off;
      end
      default: sz_w = 1'b1;
    endcase
  end

  assign err = (sz_h & off[0]) |
               (sz_w & (off != 2'b00)) |
               (a_rd & a_wr);

  assign wdat_sh = a_wdat << {off, 3'b000};
  assign rword   = mem[idx];
  assign rsh     = rword >> {off, 3'b000};

  always_comb begin
    rdat = rsh;
    if (sz_b) rdat = {24'd0, rsh[7:0]};
    if (sz_h) rdat = {16'd0, rsh[15:0]};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WS_LOAD;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign acc = (state != RESP) && (state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      o_data_rd <= 32'd0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      addr_q    <= 32'd0;
      wdat_q    <= 32'd0;
      ctrl_q    <= 4'd0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      o_ack <= acc;
      o_err <= acc & err;
      if (state == IDLE && req) begin
        addr_q <= i_data_addr;
        wdat_q <= i_data_wr;
        ctrl_q <= i_data_rd_en_ctrl;
        rd_q   <= i_data_rd_en_ma;
        wr_q   <= i_data_wr_en_ma;
      end
      if (acc) begin
        if (err)       o_data_rd <= 32'd0;
        else if (a_rd) o_data_rd <= rdat;
      end
    end
  end

  // Array has no reset; only lanes of a clean write commit
  always_ff @(posedge clk) begin
    if (!rst && acc && a_wr && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[idx][8*i +: 8] <= wdat_sh[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 3 wait states)
// against a byte-array reference model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst0, rst3;
  logic [31:0] addr, wdat;
  logic [3:0]  ctrl;
  logic        rd0, wr0, rd3, wr3;
  logic [31:0] rdat0, rdat3;
  logic        ack0, ack3, stall0, stall3, err0, err3;

  int checks;
  int failures;
  time last_ack;

  logic [7:0] mdl [2][4096];

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst0),
    .i_data_addr(addr), .i_data_wr(wdat),
    .i_data_rd_en_ctrl(ctrl),
    .i_data_rd_en_ma(rd0), .i_data_wr_en_ma(wr0),
    .o_data_rd(rdat0), .o_ack(ack0),
    .o_stall(stall0), .o_err(err0)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(3)) u3 (
    .clk(clk), .rst(rst3),
    .i_data_addr(addr), .i_data_wr(wdat),
    .i_data_rd_en_ctrl(ctrl),
    .i_data_rd_en_ma(rd3), .i_data_wr_en_ma(wr3),
    .o_data_rd(rdat3), .o_ack(ack3),
    .o_stall(stall3), .o_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic f_ack(input int u);
    return (u == 0) ? ack0 : ack3;
  endfunction
  function automatic logic f_stall(input int u);
    return (u == 0) ? stall0 : stall3;
  endfunction
  function automatic logic f_err(input int u);
    return (u == 0) ? err0 : err3;
  endfunction
  function automatic logic [31:0] f_rd(input int u);
    return (u == 0) ? rdat0 : rdat3;
  endfunction

  task automatic set_req(input int u, input logic r, input logic w);
    if (u == 0) begin rd0 = r; wr0 = w; end
    else        begin rd3 = r; wr3 = w; end
  endtask

  // Entered and left one time unit after a rising edge, in IDLE
  task automatic access(input int u, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] c, output logic [31:0] got);
    int ws, sz, off, base, n;
    logic e;
    logic [31:0] exp;
    ws   = (u == 0) ? 0 : 3;
    sz   = (c == 4'b0001) ? 1 : (c == 4'b0011) ? 2 : 4;
    off  = int'(a[1:0]);
    base = int'(a[11:0]);
    e    = (r && w) || (sz == 2 && off % 2 == 1) || (sz == 4 && off != 0);
    exp  = 32'd0;
    if (!e && r)
      for (int i = 0; i < sz; i++) exp[8*i +: 8] = mdl[u][base+i];
    if (!e && w)
      for (int i = 0; i < sz; i++) mdl[u][base+i] = d[8*i +: 8];
    addr = a;
    wdat = d;
    ctrl = c;
    set_req(u, r, w);
    #1;
    chk("stall_on_req", 32'(f_stall(u)), 32'd1);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (f_ack(u)) break;
      chk("stall_wait", 32'(f_stall(u)), 32'd1);
      if (n > 40) begin
        chk("ack_timeout", 32'(n), 32'(ws + 1));
        break;
      end
    end
    last_ack = $time;
    chk("ack_latency", 32'(n), 32'(ws + 1));
    chk("stall_in_ack", 32'(f_stall(u)), 32'd0);
    chk("err", 32'(f_err(u)), 32'(e));
    if (r || e) chk("rdata", f_rd(u), exp);
    got = f_rd(u);
    set_req(u, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("ack_one_cycle", 32'(f_ack(u)), 32'd0);
    chk("err_one_cycle", 32'(f_err(u)), 32'd0);
    if (r || e) chk("rdata_hold", f_rd(u), exp);
  endtask

  initial begin
    logic [31:0] got, r32;
    time t1;
    int sel, typ;
    logic [3:0] c;
    checks   = 0;
    failures = 0;
    rst0 = 1'b1; rst3 = 1'b1;
    addr = 32'd0; wdat = 32'd0; ctrl = 4'd0;
    rd0 = 1'b0; wr0 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_rd0", rdat0, 32'd0);
    chk("rst_ack3", 32'(ack3), 32'd0);
    chk("rst_rd3", rdat3, 32'd0);
    chk("rst_stall", 32'(stall0), 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk);
    #1;

    for (int w = 0; w < 64; w++)
      access(0, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, got);
    for (int w = 0; w < 16; w++)
      access(1, 1'b0, 1'b1, 32'(w * 4), $urandom, 4'hF, got);

    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, got);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, got);
    chk("word_load", got, 32'hDEADBEEF);
    access(0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF, got);
    access(0, 1'b0, 1'b1, 32'h12, 32'h000000A5, 4'h1, got);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, got);
    chk("byte_merge", got, 32'h11A53344);
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h1, got);
    chk("byte_load", got, 32'h000000A5);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h3, got);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, got);
    chk("mis_unchanged", got, 32'h11A53344);
    access(0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, got);
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, got);
    access(0, 1'b1, 1'b0, 32'h7000_0010, 32'h0, 4'hF, got);
    chk("addr_wrap", got, 32'h11A53344);

    for (int k = 0; k < 200; k++) begin
      r32 = $urandom;
      sel = $urandom_range(0, 3);
      typ = $urandom_range(0, 9);
      c = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h3 :
          (sel == 2) ? 4'hF : 4'($urandom);
      access(0, typ == 0 || typ > 4, typ <= 4,
             {r32[31:12], 4'h0, 8'($urandom_range(0, 255))},
             $urandom, c, got);
    end

    access(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, got);
    t1 = last_ack;
    access(1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF, got);
    chk("b2b_spacing", 32'((last_ack - t1) / 10), 32'd5);
    for (int k = 0; k < 20; k++) begin
      typ = $urandom_range(0, 9);
      sel = $urandom_range(0, 2);
      c = (sel == 0) ? 4'h1 : (sel == 1) ? 4'h3 : 4'hF;
      access(1, typ == 0 || typ > 4, typ <= 4,
             32'($urandom_range(0, 63)), $urandom, c, got);
    end

    access(1, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, got);
    addr = 32'h30;
    wdat = 32'h12345678;
    ctrl = 4'hF;
    wr3  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wait_ack_c1", 32'(ack3), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_wait_ack_c2", 32'(ack3), 32'd0);
    rst3 = 1'b1;
    wr3  = 1'b0;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    chk("rst_abandon_ack", 32'(ack3), 32'd0);
    chk("rst_abandon_stall", 32'(stall3), 32'd0);
    chk("rst_abandon_rd", rdat3, 32'd0);
    access(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'hF, got);
    chk("rst_no_commit", got, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the 5-stage RISC-V pipeline. It sits on the far side of the MEM-stage data port and accepts the read and write requests that the MEM stage drives. It aligns byte, half-word and word accesses onto a word-organised RAM and returns load data right-justified, so the MEM stage only has to sign- or zero-extend bits [7:0] or [15:0]. A programmable number of wait states is inserted, and a request/ack handshake lets the pipeline freeze its clock enable while an access is in flight.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two; index = i_data_addr[log2(DEPTH)+1:2]
- WAIT_STATES, 0, extra cycles between request capture and response; 0..15
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_data_addr  input  32  byte address from MEM stage
- i_data_wr  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- i_data_rd_en_ctrl  input  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; any other code is treated as word
- i_data_rd_en_ma  input  1  read request
- i_data_wr_en_ma  input  1  write request
- o_data_rd  output  32  load data, right-justified, zero-filled above access size
- o_ack  output  1  one-cycle pulse: access complete, o_data_rd valid
- o_stall  output  1  combinational: request present and o_ack low; drives pipeline clk_en low
- o_err  output  1  one-cycle pulse with o_ack: misaligned access or simultaneous rd+wr

## Operation
- FSM states:
  - IDLE: a request (rd_en or wr_en high) latches addr, data, ctrl and type. Go to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: down-counter loaded with WAIT_STATES-1 on entry; go to RESP when the counter is 0.
  - RESP: o_ack=1 for exactly one cycle; inputs are ignored; always return to IDLE.
- The array access is performed on the clock edge that enters RESP. Reads are registered into o_data_rd. Writes commit on the same edge.
- Byte offset off = latched addr[1:0].
- Write lane mask:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- Write data is i_data_wr shifted left by 8*off. Only masked lanes are updated.
- Read data is word >> 8*off, then masked to 8, 16 or 32 bits. Unused upper bits are 0.
- Misaligned conditions:
  - half with off[0]=1
  - word with off≠0
- On a misaligned access: no array write, o_data_rd=0, o_err=1 in RESP.
- Both rd_en and wr_en high in IDLE: treated as an error access. No write, o_data_rd=0, o_err=1.
- Address bits above the index are ignored, so addresses wrap modulo DEPTH*4.
- o_data_rd holds its value until the next RESP. It is not cleared on return to IDLE.

## Timing
- Request sampled in cycle t (IDLE) → o_ack in cycle t+1+WAIT_STATES.
- Write is visible to a read request sampled at t+2+WAIT_STATES or later.
- Throughput: one access per WAIT_STATES+2 cycles.
- The requester holds the request stable while o_stall=1. It must drop the request, or present the next one, in the cycle after o_ack. A request still high in the cycle after RESP is treated as a new access.
- o_stall = (rd_en | wr_en) & ~o_ack. It is low in the ack cycle so the pipeline advances on that edge.
- Reset values: state=IDLE, counter=0, o_data_rd=0, o_ack=0, o_err=0; o_stall follows its inputs.
- Reset in WAIT: the access is abandoned, the write does not commit and no ack is issued. Array contents are not cleared by reset.
- Reset has priority over every other event in the same cycle.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 (WAIT_STATES=0) → write ack at t+1; load o_data_rd=0xDEADBEEF, o_err=0.
- Byte store 0xA5 @0x12 over word 0x11223344 @0x10, then word load @0x10 → 0x11A53344; byte load @0x12 → 0x000000A5.
- Half load @0x13 → o_err=1 with o_ack, o_data_rd=0; a following word load @0x10 shows memory unchanged.
- rd_en and wr_en both high @0x20 with data 0xFFFFFFFF → o_err=1; a word load @0x20 returns the prior contents.
- WAIT_STATES=3: word load requested at cycle 0 → o_stall=1 for cycles 0–3, o_ack at cycle 4; back-to-back requests are spaced 5 cycles apart.
- WAIT_STATES=3: word store 0x12345678 @0x30 with rst pulsed in cycle 2 → no o_ack; a following load @0x30 returns the old value; state is IDLE one cycle after rst.
